// File: rtl/demux2_stage_if.sv
// Handshake bundle for demux2_stage: one valid/ready input and two valid/ready outputs,
// plus the per-port transfer counters and their clear.
interface demux2_stage_if #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic             cnt_clr;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

  // Producer / consumers side
  modport master (
    output in_valid, in_data, in_sel, out0_ready, out1_ready, cnt_clr,
    input  in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );

  // Demux side
  modport slave (
    input  in_valid, in_data, in_sel, out0_ready, out1_ready, cnt_clr,
    output in_ready, out0_valid, out0_data, out1_valid, out1_data, cnt0, cnt1
  );
endinterface

// File: rtl/demux2_stage.sv
// Registered 1-to-2 demultiplexer with a single-entry buffer and per-port transfer counters.
// A word pushed at edge N is presented on its selected port from edge N onward; a pop in the
// same cycle as a push lets one word per cycle stream through.
module demux2_stage #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned CNT_W = 16
) (
  input logic           clk,
  input logic           reset,
  demux2_stage_if.slave bus
);

  typedef enum logic [0:0] {StEmpty, StFull} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_data;
  logic             r_sel;
  logic [CNT_W-1:0] r_cnt0;
  logic [CNT_W-1:0] r_cnt1;

  logic w_full;
  logic w_pop0;
  logic w_pop1;
  logic w_pop;
  logic w_push;

  // State register: buffer occupancy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a push always leaves the buffer full; a lone pop empties it
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StEmpty: if (w_push) w_state_next = StFull;
      StFull:  if (w_pop && !w_push) w_state_next = StEmpty;
      default: w_state_next = StEmpty;
    endcase
  end

  // Outputs: valids come from registers only; in_ready also sees this cycle's pop
  always_comb begin
    w_full         = (r_state == StFull);
    bus.out0_valid = w_full & ~r_sel;
    bus.out1_valid = w_full & r_sel;
    bus.out0_data  = r_data;
    bus.out1_data  = r_data;
    // Ready on the port that is not selected never pops
    w_pop0         = bus.out0_valid & bus.out0_ready;
    w_pop1         = bus.out1_valid & bus.out1_ready;
    w_pop          = w_pop0 | w_pop1;
    bus.in_ready   = ~w_full | w_pop;
    w_push         = bus.in_valid & bus.in_ready;
    bus.cnt0       = r_cnt0;
    bus.cnt1       = r_cnt1;
  end

  // Buffer payload: load on push, otherwise hold (including after a pop)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_sel  <= 1'b0;
    end else if (w_push) begin
      r_data <= bus.in_data;
      r_sel  <= bus.in_sel;
    end
  end

  // Transfer counters: clear wins over a same-cycle pop; increments wrap naturally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else if (bus.cnt_clr) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_pop0) r_cnt0 <= r_cnt0 + 1'b1;
      if (w_pop1) r_cnt1 <= r_cnt1 + 1'b1;
    end
  end

endmodule

// File: tb/tb_demux2_stage.sv
// Bench for demux2_stage: random and directed traffic checked every cycle against a
// queue-based reference, plus literal expectations for the directed scenarios.
module tb_demux2_stage;
  localparam int unsigned WIDTH = 64;
  localparam int unsigned CNT_W = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic chk_en = 1'b0;

  int n_total = 0;
  int n_bad = 0;

  demux2_stage_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux2_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference: the buffer is a queue of {sel, data} holding at most one word
  logic [WIDTH:0]   m_q[$];
  logic [WIDTH-1:0] m_last = '0;
  logic [CNT_W-1:0] m_cnt0 = '0;
  logic [CNT_W-1:0] m_cnt1 = '0;
  logic             e_v0, e_v1, e_pop0, e_pop1, e_rdy, e_push;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare DUT against the reference each falling edge, then advance the reference
  // using the inputs that the next rising edge will sample.
  initial begin
    forever begin
      @(negedge clk or posedge reset);
      if (reset) begin
        m_q.delete();
        m_last = '0;
        m_cnt0 = '0;
        m_cnt1 = '0;
      end else if (chk_en) begin
        e_v0   = (m_q.size() == 1) && !m_q[0][WIDTH];
        e_v1   = (m_q.size() == 1) && m_q[0][WIDTH];
        e_pop0 = e_v0 && bus.out0_ready;
        e_pop1 = e_v1 && bus.out1_ready;
        e_rdy  = (m_q.size() == 0) || e_pop0 || e_pop1;
        e_push = bus.in_valid && e_rdy;
        chk("m_in_ready", 64'(bus.in_ready), 64'(e_rdy));
        chk("m_out0_valid", 64'(bus.out0_valid), 64'(e_v0));
        chk("m_out1_valid", 64'(bus.out1_valid), 64'(e_v1));
        chk("m_out0_data", bus.out0_data, m_last);
        chk("m_out1_data", bus.out1_data, m_last);
        chk("m_cnt0", 64'(bus.cnt0), 64'(m_cnt0));
        chk("m_cnt1", 64'(bus.cnt1), 64'(m_cnt1));
        if (e_pop0 || e_pop1) void'(m_q.pop_front());
        if (e_push) begin
          m_q.push_back({bus.in_sel, bus.in_data});
          m_last = bus.in_data;
        end
        if (bus.cnt_clr) begin
          m_cnt0 = '0;
          m_cnt1 = '0;
        end else begin
          if (e_pop0) m_cnt0 = m_cnt0 + 1'b1;
          if (e_pop1) m_cnt1 = m_cnt1 + 1'b1;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic iv, input logic [WIDTH-1:0] d, input logic s,
                       input logic r0, input logic r1, input logic clr);
    bus.in_valid   = iv;
    bus.in_data    = d;
    bus.in_sel     = s;
    bus.out0_ready = r0;
    bus.out1_ready = r1;
    bus.cnt_clr    = clr;
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_out0_valid", 64'(bus.out0_valid), 64'd0);
    chk("rst_out0_data", bus.out0_data, 64'd0);
    chk("rst_cnt0", 64'(bus.cnt0), 64'd0);
    #1 reset = 1'b0;
    chk_en = 1'b1;
    #1 chk("rst_in_ready", 64'(bus.in_ready), 64'd1);

    // Single word to port 0
    step(); drive(1'b1, 64'h1111, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); drive(1'b0, 64'hdead, 1'b1, 1'b1, 1'b1, 1'b0);
    at_neg();
    chk("t1_out0_valid", 64'(bus.out0_valid), 64'd1);
    chk("t1_out0_data", bus.out0_data, 64'h1111);
    chk("t1_out1_valid", 64'(bus.out1_valid), 64'd0);
    at_neg();
    chk("t1_out0_gone", 64'(bus.out0_valid), 64'd0);
    chk("t1_cnt0", 64'(bus.cnt0), 64'd1);
    chk("t1_cnt1", 64'(bus.cnt1), 64'd0);

    // Back-to-back A@0, B@1, C@0
    step(); drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); drive(1'b1, 64'hA, 1'b0, 1'b1, 1'b1, 1'b0);
    at_neg(); chk("t2_rdy_a", 64'(bus.in_ready), 64'd1);
    step(); drive(1'b1, 64'hB, 1'b1, 1'b1, 1'b1, 1'b0);
    at_neg();
    chk("t2_rdy_b", 64'(bus.in_ready), 64'd1);
    chk("t2_a_v0", 64'(bus.out0_valid), 64'd1);
    chk("t2_a_data", bus.out0_data, 64'hA);
    step(); drive(1'b1, 64'hC, 1'b0, 1'b1, 1'b1, 1'b0);
    at_neg();
    chk("t2_rdy_c", 64'(bus.in_ready), 64'd1);
    chk("t2_b_v1", 64'(bus.out1_valid), 64'd1);
    chk("t2_b_v0", 64'(bus.out0_valid), 64'd0);
    chk("t2_b_data", bus.out1_data, 64'hB);
    step(); drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    at_neg();
    chk("t2_c_v0", 64'(bus.out0_valid), 64'd1);
    chk("t2_c_data", bus.out0_data, 64'hC);
    at_neg();
    chk("t2_cnt0", 64'(bus.cnt0), 64'd2);
    chk("t2_cnt1", 64'(bus.cnt1), 64'd1);

    // Stall on port 1 while port 0 is ready
    step(); drive(1'b1, 64'h55, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); drive(1'b1, 64'h66, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      at_neg();
      chk("t3_stall_rdy", 64'(bus.in_ready), 64'd0);
      chk("t3_stall_v1", 64'(bus.out1_valid), 64'd1);
      chk("t3_stall_data", bus.out1_data, 64'h55);
      chk("t3_stall_cnt1", 64'(bus.cnt1), 64'd1);
      if (i < 2) step();
    end
    step(); drive(1'b1, 64'h66, 1'b0, 1'b1, 1'b1, 1'b0);
    at_neg(); chk("t3_pass_rdy", 64'(bus.in_ready), 64'd1);
    step(); drive(1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    at_neg();
    chk("t3_next_v0", 64'(bus.out0_valid), 64'd1);
    chk("t3_next_data", bus.out0_data, 64'h66);
    chk("t3_cnt1", 64'(bus.cnt1), 64'd2);

    // Counter wrap on port 0
    step(); drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); drive(1'b1, 64'(($urandom)), 1'b0, 1'b1, 1'b0, 1'b0);
    repeat (65534) begin
      step(); bus.in_data = {$urandom, $urandom};
    end
    step(); bus.in_valid = 1'b0;
    step();
    at_neg(); chk("t4_cnt0_max", 64'(bus.cnt0), 64'hFFFF);
    step(); drive(1'b1, 64'h9, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); bus.in_valid = 1'b0;
    step();
    at_neg(); chk("t4_cnt0_wrap", 64'(bus.cnt0), 64'h0);
    step(); drive(1'b1, 64'h31, 1'b1, 1'b1, 1'b1, 1'b0);
    step(); bus.in_valid = 1'b0;
    step();
    at_neg(); chk("t4_cnt1_one", 64'(bus.cnt1), 64'd1);
    step(); drive(1'b1, 64'h32, 1'b1, 1'b1, 1'b0, 1'b0);
    step(); bus.in_valid = 1'b0;
    at_neg(); chk("t4_held_v1", 64'(bus.out1_valid), 64'd1);
    step(); drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
    step(); bus.cnt_clr = 1'b0;
    at_neg();
    chk("t4_clr_cnt1", 64'(bus.cnt1), 64'd0);
    chk("t4_clr_v1", 64'(bus.out1_valid), 64'd0);

    // Random traffic
    repeat (3000) begin
      step();
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 1'($urandom),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7, $urandom_range(0, 39) == 0);
    end

    // Asynchronous reset while holding a word
    step(); drive(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(); step(); drive(1'b1, 64'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    step(); bus.in_valid = 1'b0;
    at_neg();
    chk("t5_held_v0", 64'(bus.out0_valid), 64'd1);
    chk("t5_held_data", bus.out0_data, 64'h77);
    reset = 1'b1;
    #1;
    chk("t5_rst_v0", 64'(bus.out0_valid), 64'd0);
    chk("t5_rst_v1", 64'(bus.out1_valid), 64'd0);
    chk("t5_rst_d0", bus.out0_data, 64'd0);
    chk("t5_rst_d1", bus.out1_data, 64'd0);
    #1 reset = 1'b0;
    bus.out0_ready = 1'b1;
    bus.out1_ready = 1'b1;
    #1 chk("t5_in_ready", 64'(bus.in_ready), 64'd1);
    repeat (3) step();
    at_neg();
    chk("t5_after_v0", 64'(bus.out0_valid), 64'd0);
    chk("t5_after_cnt0", 64'(bus.cnt0), 64'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
